// File: rtl/p2s_serializer.sv
// p2s_serializer: parameterised parallel-to-serial converter with a one-word
// holding buffer, so frames can be sent back to back with no gap.
//
// Parameters
//   W          data word width (>= 2)
//   MSB_FIRST  0: din[0] leaves first, 1: din[W-1] leaves first
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset, highest priority
//   din        parallel word, captured into HOLD on an accepted load
//   load       load request, accepted when load_rdy=1
//   load_rdy   holding buffer empty (combinational, !hold_full)
//   send       shift enable; 0 freezes the frame in place
//   dout       serial bit (registered)
//   dout_vld   dout is a valid bit this cycle (registered)
//   dout_last  dout is the final bit of a word (registered)
//   busy       shifting or a word is buffered
//   ovr        sticky: a load arrived while the buffer was full
module p2s_serializer #(
  parameter int W         = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         load,
  output logic         load_rdy,
  input  logic         send,
  output logic         dout,
  output logic         dout_vld,
  output logic         dout_last,
  output logic         busy,
  output logic         ovr
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [W-1:0]  hold;
  logic          hold_full;
  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;      // bits still to send from sr

  logic          next_bit;
  logic [W-1:0]  sr_shift;

  // Output end of sr and the shifted value; the vacated bit fills with 0.
  assign next_bit = (MSB_FIRST != 0) ? sr[W-1] : sr[0];
  assign sr_shift = (MSB_FIRST != 0) ? {sr[W-2:0], 1'b0} : {1'b0, sr[W-1:1]};

  assign load_rdy = !hold_full;
  assign busy     = (state == SHIFT) || hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      sr        <= '0;
      cnt       <= '0;
      dout      <= 1'b0;
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      // Load side. A load can only be accepted while hold is empty, so it
      // never collides with the hold->sr transfer below that clears hold_full.
      if (load) begin
        if (!hold_full) begin
          hold      <= din;
          hold_full <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          dout      <= 1'b0;
          dout_vld  <= 1'b0;
          dout_last <= 1'b0;
          if (hold_full) begin
            sr        <= hold;
            cnt       <= CW'(W);
            hold_full <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (send) begin
            dout      <= next_bit;
            dout_vld  <= 1'b1;
            dout_last <= (cnt == CW'(1));
            sr        <= sr_shift;
            cnt       <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              // Chain straight into the buffered word so the next send
              // cycle carries its first bit with no bubble.
              if (hold_full) begin
                sr        <= hold;
                cnt       <= CW'(W);
                hold_full <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end
          end else begin
            dout_vld  <= 1'b0;
            dout_last <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_serializer.sv
module tb_p2s_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: W=4 LSB first, B: W=4 MSB first, C: W=8 LSB first
  logic [3:0] a_din; logic a_load, a_send;
  logic a_rdy, a_dout, a_vld, a_last, a_busy, a_ovr;
  logic [3:0] b_din; logic b_load, b_send;
  logic b_rdy, b_dout, b_vld, b_last, b_busy, b_ovr;
  logic [7:0] c_din; logic c_load, c_send;
  logic c_rdy, c_dout, c_vld, c_last, c_busy, c_ovr;

  p2s_serializer #(.W(4), .MSB_FIRST(0)) u_a (
    .clk(clk), .rst(rst), .din(a_din), .load(a_load), .load_rdy(a_rdy),
    .send(a_send), .dout(a_dout), .dout_vld(a_vld), .dout_last(a_last),
    .busy(a_busy), .ovr(a_ovr));
  p2s_serializer #(.W(4), .MSB_FIRST(1)) u_b (
    .clk(clk), .rst(rst), .din(b_din), .load(b_load), .load_rdy(b_rdy),
    .send(b_send), .dout(b_dout), .dout_vld(b_vld), .dout_last(b_last),
    .busy(b_busy), .ovr(b_ovr));
  p2s_serializer #(.W(8), .MSB_FIRST(0)) u_c (
    .clk(clk), .rst(rst), .din(c_din), .load(c_load), .load_rdy(c_rdy),
    .send(c_send), .dout(c_dout), .dout_vld(c_vld), .dout_last(c_last),
    .busy(c_busy), .ovr(c_ovr));

  // Scoreboards: each entry is {expected bit, expected last flag}.
  logic [1:0] qa[$];
  logic [1:0] qb[$];
  logic [1:0] qc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_a(input logic [3:0] w);
    for (int i = 0; i < 4; i++) qa.push_back({w[i], 1'(i == 3)});
  endfunction
  function automatic void push_b(input logic [3:0] w);
    for (int i = 0; i < 4; i++) qb.push_back({w[3-i], 1'(i == 3)});
  endfunction
  function automatic void push_c(input logic [7:0] w);
    for (int i = 0; i < 8; i++) qc.push_back({w[i], 1'(i == 7)});
  endfunction

  // Monitors pop one expected bit per valid output cycle.
  always @(negedge clk) begin
    logic [1:0] e;
    if (a_vld === 1'b1) begin
      if (qa.size() == 0) chk("a_unexpected_bit", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_bit", a_dout, e[1]);
        chk("a_last", a_last, e[0]);
      end
    end
  end
  always @(negedge clk) begin
    logic [1:0] e;
    if (b_vld === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected_bit", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_bit", b_dout, e[1]);
        chk("b_last", b_last, e[0]);
      end
    end
  end
  always @(negedge clk) begin
    logic [1:0] e;
    if (c_vld === 1'b1) begin
      if (qc.size() == 0) chk("c_unexpected_bit", 1, 0);
      else begin
        e = qc.pop_front();
        chk("c_bit", c_dout, e[1]);
        chk("c_last", c_last, e[0]);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    a_din = '0; a_load = 0; a_send = 0;
    b_din = '0; b_load = 0; b_send = 0;
    c_din = '0; c_load = 0; c_send = 0;
    tick(2);

    // Reset state
    chk("rst_a_outs", {a_dout, a_vld, a_last, a_busy, a_ovr, a_rdy}, 6'b000001);
    chk("rst_b_outs", {b_dout, b_vld, b_last, b_busy, b_ovr, b_rdy}, 6'b000001);
    chk("rst_c_outs", {c_dout, c_vld, c_last, c_busy, c_ovr, c_rdy}, 6'b000001);
    rst = 1'b0;
    tick();

    // A: 1001 LSB first -> 1,0,0,1, with latency load->transfer->bit
    a_din = 4'b1001; a_load = 1; push_a(4'b1001);
    tick();                                   // load accepted
    a_load = 0; a_send = 1;                   // send in IDLE does nothing
    chk("a_rdy_after_load", a_rdy, 0);
    chk("a_vld_load_edge", a_vld, 0);
    tick();                                   // transfer
    chk("a_vld_xfer_edge", a_vld, 0);
    chk("a_rdy_after_xfer", a_rdy, 1);
    tick();                                   // first bit
    chk("a_vld_first_bit", a_vld, 1);
    tick(3);
    a_send = 0;
    tick();
    chk("a_busy_done", a_busy, 0);
    chk("a_vld_done", a_vld, 0);

    // B: 0011 MSB first -> 0,0,1,1
    b_din = 4'b0011; b_load = 1; b_send = 1; push_b(4'b0011);
    tick();
    b_load = 0;
    chk("b_rdy_after_load", b_rdy, 0);
    tick();
    chk("b_rdy_returns", b_rdy, 1);
    tick(4);
    tick();
    b_send = 0;
    chk("b_busy_done", b_busy, 0);

    // C: back-to-back A5 then 3C, 16 contiguous valid bits
    c_din = 8'hA5; c_load = 1; push_c(8'hA5);
    tick();
    c_load = 0; c_send = 1;
    tick();                                   // transfer
    c_din = 8'h3C; c_load = 1; push_c(8'h3C);
    tick();                                   // bit 1, second word buffered
    c_load = 0;
    chk("c_vld_bit1", c_vld, 1);
    chk("c_rdy_full", c_rdy, 0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("c_contiguous_vld", c_vld, 1);
    end
    tick();
    c_send = 0;
    chk("c_vld_after_16", c_vld, 0);
    chk("c_busy_after_16", c_busy, 0);

    // A: pause after 2nd bit of 1010 (bits 0,1,0,1)
    a_din = 4'b1010; a_load = 1; push_a(4'b1010);
    tick();
    a_load = 0; a_send = 1;
    tick();                                   // transfer
    tick(2);                                  // bits 0,1
    a_send = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("a_pause_vld", a_vld, 0);
      chk("a_pause_dout", a_dout, 1);
      chk("a_pause_busy", a_busy, 1);
    end
    a_send = 1;
    tick(2);
    a_send = 0;
    tick();
    chk("a_pause_busy_done", a_busy, 0);
    chk("a_pause_q_empty", qa.size(), 0);

    // A: overrun while shifting with hold full; 4'hF must never appear
    a_din = 4'b0110; a_load = 1; push_a(4'b0110);
    tick();
    a_load = 0; a_send = 1;
    tick();                                   // transfer
    a_din = 4'b1100; a_load = 1; push_a(4'b1100);
    tick();                                   // bit 1, hold full
    chk("a_ovr_before", a_ovr, 0);
    a_din = 4'hF;                             // load still high, rdy low
    tick();                                   // bit 2, overrun
    a_load = 0;
    chk("a_ovr_set", a_ovr, 1);
    tick(6);
    tick();
    a_send = 0;
    chk("a_ovr_sticky", a_ovr, 1);
    chk("a_ovr_busy_done", a_busy, 0);
    chk("a_ovr_q_empty", qa.size(), 0);

    // C: reset after 2 of 8 bits with hold full
    c_din = 8'h5A; c_load = 1; push_c(8'h5A);
    tick();
    c_load = 0; c_send = 1;
    tick();                                   // transfer
    c_din = 8'hC3; c_load = 1; push_c(8'hC3);
    tick();                                   // bit 1
    c_load = 0;
    tick();                                   // bit 2
    rst = 1; c_send = 0;
    tick();                                   // reset edge
    qc.delete();                              // in-flight and buffered words dropped
    chk("c_rst_outs", {c_dout, c_vld, c_last, c_ovr}, 4'b0000);
    chk("c_rst_rdy", c_rdy, 1);
    chk("c_rst_busy", c_busy, 0);
    chk("a_rst_ovr_clr", a_ovr, 0);
    rst = 0;
    c_din = 8'h96; c_load = 1; push_c(8'h96);
    tick();
    c_load = 0; c_send = 1;
    tick();
    tick(8);
    tick();
    c_send = 0;
    chk("c_post_rst_busy", c_busy, 0);

    tick(2);
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    chk("qc_empty", qc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/p2s_serializer.md
Name: p2s_serializer

Overview:
- Parametrised parallel-to-serial converter, the next generation of the 4-bit load/send block.
- Adds configurable width, bit-order mode, a one-word holding buffer for back-to-back frames, a ready/overrun handshake, and a last-bit marker.
- Sits between a word-producing datapath (load side) and a bit-serial link (send side). Runs in a single clock domain.

Parameters:
- W, 8, data word width in bits; legal range W >= 2.
- MSB_FIRST, 0, bit order: 0 sends din[0] first, 1 sends din[W-1] first.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- din  input  W  parallel word, sampled on an accepted load.
- load  input  1  load request; accepted when load=1 and load_rdy=1.
- load_rdy  output  1  holding buffer empty; combinational, equals !hold_full.
- send  input  1  shift enable; 0 pauses the frame in place.
- dout  output  1  serial data, registered.
- dout_vld  output  1  dout carries a valid bit this cycle, registered.
- dout_last  output  1  current dout is the final bit of a word, registered.
- busy  output  1  state==SHIFT or hold_full.
- ovr  output  1  sticky overrun flag; load attempted while load_rdy=0.

Behaviour:
- Reset: rst=1 at an edge clears state to IDLE.
  - Also clears hold_full, cnt, SR, HOLD, dout, dout_vld, dout_last and ovr to 0.
  - Reset mid-frame discards the in-flight and buffered words with no partial-word flush.
  - Reset has priority over every other event.
- Storage:
  - HOLD[W-1:0] plus hold_full.
  - Shift register SR[W-1:0].
  - Bit counter cnt, width $clog2(W)+1, holding the bits remaining.
- Load:
  - An accepted load at an edge writes HOLD<=din and hold_full<=1.
  - Load with load_rdy=0 is ignored: HOLD is unchanged and ovr<=1. ovr stays set until rst.
- FSM IDLE:
  - dout_vld<=0, dout_last<=0, dout<=0.
  - If hold_full: SR<=HOLD, cnt<=W, hold_full<=0, and next state is SHIFT.
  - An accepted load and a transfer cannot coincide, because load_rdy=0 whenever hold_full=1.
- FSM SHIFT with send=1 at an edge:
  - dout<=next bit: SR[0] if MSB_FIRST=0, SR[W-1] if MSB_FIRST=1.
  - dout_vld<=1.
  - SR shifts toward the output end; the vacated bit is filled with 0.
  - cnt<=cnt-1.
  - dout_last<=(cnt==1).
- End of word (cnt==1 with send=1):
  - If hold_full: SR<=HOLD, cnt<=W, hold_full<=0, stay in SHIFT. The next word's first bit follows on the very next send cycle, with no bubble.
  - Otherwise: next state is IDLE.
- FSM SHIFT with send=0:
  - dout_vld<=0 and dout_last<=0.
  - dout, SR and cnt hold.
  - Loads into HOLD are still accepted.
- Latency: accepted load at edge N (SR empty) -> transfer at N+1 -> first dout_vld=1 at edge N+2 if send=1.
- Frame length: exactly W dout_vld pulses per loaded word. Words leave in load order, never reordered or dropped, except on overrun or reset.
- busy goes to 0 one cycle after the last bit, provided no word is buffered.
- send=1 in IDLE has no effect.

Test Plan:
- W=4, MSB_FIRST=0: load din=4'b1001 at t=3, send=1 from t=6 for 4 cycles -> dout=1,0,0,1 with dout_vld=1 each cycle; dout_last=1 only on the 4th bit; busy=0 afterwards.
- W=4, MSB_FIRST=1: load 4'b0011, send held high -> dout=0,0,1,1; load_rdy returns to 1 one cycle after the load.
- Back-to-back, W=8: load 8'hA5, then load 8'h3C while the first word is shifting, send held high -> 16 contiguous dout_vld cycles with no gap; dout_last on bits 8 and 16; bit sequence is A5 then 3C, LSB first.
- Pause: W=4 word 4'b1010, send low for 3 cycles after the 2nd bit -> dout_vld=0 during the pause and dout holds 1; the remaining bits 0,1 resume; exactly 4 valid bits in total.
- Overrun: with SR shifting and HOLD full, assert load with din=4'hF -> ovr=1 and stays 1; the buffered word is transmitted unchanged; the 4'hF word is never sent.
- Reset mid-frame: rst=1 after 2 of 8 bits with HOLD full -> next cycle all outputs are 0, load_rdy=1 and busy=0; a subsequent load/send sends a full clean 8-bit word.
